// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC arithmetic cluster, including the
// iterative divider's state encoding and magnitude helper.
package mac_pkg;

  localparam int unsigned DIV_DW = 8;
  localparam int unsigned MAG_W  = 64;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } div_state_e;

  // Width of the down-counter that sequences 2*dw restoring steps.
  function automatic int unsigned step_cnt_w(input int unsigned dw);
    return $clog2(2 * dw);
  endfunction

  // Conditional two's-complement negate; callers zero-extend and truncate.
  function automatic logic [MAG_W-1:0] abs_mag(input logic [MAG_W-1:0] x,
                                               input logic             neg);
    return neg ? (~x + MAG_W'(1)) : x;
  endfunction

endpackage

// File: rtl/mac_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor magnitude, keep the difference only when it is non-negative.
module mac_div_step #(
  parameter int unsigned DW = 8
) (
  input  logic [DW:0]   pr_i,
  input  logic          bit_i,
  input  logic [DW-1:0] dvs_i,
  output logic [DW:0]   pr_o,
  output logic          q_o
);

  logic [DW+1:0] shifted;
  logic [DW+1:0] diff;

  // The incoming partial remainder is always below |D|, so the shifted value
  // stays under 2^(DW+1) and the top bit of diff is a clean borrow flag.
  always_comb begin
    shifted = {pr_i, bit_i};
    diff    = shifted - {2'b00, dvs_i};
    q_o     = ~diff[DW+1];
    pr_o    = q_o ? diff[DW:0] : shifted[DW:0];
  end

endmodule

// File: rtl/mac_div_iter.sv
// Iterative restoring divider (2*DW / DW) with valid/ready on both sides,
// producing one quotient bit per cycle with truncating signed semantics.
module mac_div_iter
  import mac_pkg::*;
#(
  parameter int unsigned DW = DIV_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] N,
  input  logic [DW-1:0]   D,
  input  logic            Signed,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] quo,
  output logic [DW-1:0]   rem,
  output logic            div_zero,
  output logic            ovf
);

  localparam int unsigned NW    = 2 * DW;
  localparam int unsigned CNT_W = step_cnt_w(DW);
  localparam logic [NW-1:0] N_MIN = {1'b1, {(NW-1){1'b0}}};

  div_state_e        state_q, state_d;
  logic [NW-1:0]     n_q, n_d;
  logic [DW-1:0]     d_q, d_d;
  logic              sgn_q, sgn_d;
  logic [NW-1:0]     dvd_q, dvd_d;
  logic [DW-1:0]     dvs_q, dvs_d;
  logic [DW:0]       pr_q, pr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [NW-1:0]     quo_q, quo_d;
  logic [DW-1:0]     rem_q, rem_d;
  logic              dz_q, dz_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;

  logic [DW:0]       step_pr;
  logic              step_q;
  logic              n_neg, d_neg;

  mac_div_step #(.DW(DW)) u_step (
    .pr_i  (pr_q),
    .bit_i (dvd_q[NW-1]),
    .dvs_i (dvs_q),
    .pr_o  (step_pr),
    .q_o   (step_q)
  );

  assign n_neg = sgn_q & n_q[NW-1];
  assign d_neg = sgn_q & d_q[DW-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      d_q         <= '0;
      sgn_q       <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      pr_q        <= '0;
      cnt_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      d_q         <= d_d;
      sgn_q       <= sgn_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      pr_q        <= pr_d;
      cnt_q       <= cnt_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    sgn_d   = sgn_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          n_d     = N;
          d_d     = D;
          sgn_d   = Signed;
          state_d = PREP;
        end
      end
      PREP: begin
        if (d_q == '0) begin
          quo_d   = '1;
          rem_d   = '0;
          dz_d    = 1'b1;
          ovf_d   = 1'b0;
          state_d = DONE;
        end else if (sgn_q && (n_q == N_MIN) && (d_q == '1)) begin
          quo_d   = n_q;
          rem_d   = '0;
          dz_d    = 1'b0;
          ovf_d   = 1'b1;
          state_d = DONE;
        end else begin
          dvd_d   = NW'(abs_mag(MAG_W'(n_q), n_neg));
          dvs_d   = DW'(abs_mag(MAG_W'(d_q), d_neg));
          pr_d    = '0;
          cnt_d   = CNT_W'(NW - 1);
          qneg_d  = n_neg ^ d_neg;
          rneg_d  = n_neg;
          state_d = CALC;
        end
      end
      // Dividend register doubles as the quotient: bits leave at the top
      // as quotient bits enter at the bottom.
      CALC: begin
        pr_d  = step_pr;
        dvd_d = {dvd_q[NW-2:0], step_q};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quo_d   = qneg_q ? (~dvd_q + NW'(1)) : dvd_q;
        rem_d   = rneg_q ? (~pr_q[DW-1:0] + DW'(1)) : pr_q[DW-1:0];
        dz_d    = 1'b0;
        ovf_d   = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // out_valid trails entry into DONE by one cycle and drops on handshake.
    out_valid_d = (state_q == DONE) && !(out_valid_q && out_ready);
    in_ready_d  = (state_d == IDLE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quo       = quo_q;
  assign rem       = rem_q;
  assign div_zero  = dz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_div_iter.sv
// Directed bench for mac_div_iter against a cycle-level behavioural model
// built on plain integer division.
module tb_mac_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        Signed = 1'b0;
  logic [15:0] N = '0;
  logic [7:0]  D = '0;
  logic        in_ready, out_valid, div_zero, ovf;
  logic [15:0] quo;
  logic [7:0]  rem;

  int total = 0;
  int bad   = 0;

  bit          m_busy = 1'b0;
  bit          m_rdy = 1'b0;
  bit          m_ov = 1'b0;
  bit          m_pristine = 1'b1;
  int          m_age = 0;
  int          m_lat = 0;
  logic [15:0] m_quo = '0, p_quo = '0;
  logic [7:0]  m_rem = '0, p_rem = '0;
  logic        m_dz = 1'b0, m_ovf = 1'b0, p_dz = 1'b0, p_ovf = 1'b0;

  mac_div_iter #(.DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .N         (N),
    .D         (D),
    .Signed    (Signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quo       (quo),
    .rem       (rem),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_div(input logic [15:0] n, input logic [7:0] d, input logic s,
                                    output logic [15:0] q, output logic [7:0] r,
                                    output logic dz, output logic ov, output int lat);
    longint nn, dd;
    nn  = s ? longint'($signed(n)) : longint'(n);
    dd  = s ? longint'($signed(d)) : longint'(d);
    dz  = 1'b0;
    ov  = 1'b0;
    lat = 19;
    if (dd == 0) begin
      q = 16'hFFFF; r = 8'h00; dz = 1'b1; lat = 2;
    end else if (s && nn == -32768 && dd == -1) begin
      q = n; r = 8'h00; ov = 1'b1; lat = 2;
    end else begin
      q = 16'(nn / dd);
      r = 8'(nn % dd);
    end
  endfunction

  task automatic do_op(input logic [15:0] n, input logic [7:0] d, input logic s,
                       input logic [15:0] eq, input logic [7:0] er, input logic edz,
                       input logic eov, input int elat, input int hold, input bit poke);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
    chk("ready_wait", 32'(in_ready), 32'd1);
    N = n; D = d; Signed = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_after_accept", 32'(in_ready), 32'd0);
    k = 0;
    while (!out_valid && k < 60) begin @(posedge clk); #1; k++; end
    chk("latency", 32'(k), 32'(elat));
    chk("quo", 32'(quo), 32'(eq));
    chk("rem", 32'(rem), 32'(er));
    chk("div_zero", 32'(div_zero), 32'(edz));
    chk("ovf", 32'(ovf), 32'(eov));
    chk("model_quo", 32'(m_quo), 32'(eq));
    chk("model_rem", 32'(m_rem), 32'(er));
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 1) begin
        N = 16'h0005; D = 8'h01; Signed = 1'b0; in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_quo", 32'(quo), 32'(eq));
      chk("hold_rem", 32'(rem), 32'(er));
      chk("hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ready_after_hs", 32'(in_ready), 32'd1);
    chk("valid_after_hs", 32'(out_valid), 32'd0);
  endtask

  initial begin
    // Behavioural model: tracks acceptance, latency and handshake.
    fork
      forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
          m_busy = 1'b0; m_rdy = 1'b0; m_ov = 1'b0; m_pristine = 1'b1;
          m_quo = '0; m_rem = '0; m_dz = 1'b0; m_ovf = 1'b0;
        end else if (!m_busy) begin
          if (m_rdy && in_valid) begin
            model_div(N, D, Signed, p_quo, p_rem, p_dz, p_ovf, m_lat);
            m_busy = 1'b1; m_rdy = 1'b0; m_age = 0; m_pristine = 1'b0;
          end else begin
            m_rdy = 1'b1;
          end
        end else if (m_ov) begin
          if (out_ready) begin
            m_ov = 1'b0; m_busy = 1'b0; m_rdy = 1'b1;
          end
        end else begin
          m_age++;
          if (m_age == m_lat) begin
            m_ov = 1'b1; m_quo = p_quo; m_rem = p_rem; m_dz = p_dz; m_ovf = p_ovf;
          end
        end
      end
      forever begin
        @(negedge clk);
        chk("cyc_out_valid", 32'(out_valid), 32'(m_ov));
        chk("cyc_in_ready", 32'(in_ready), 32'(m_rdy));
        if (m_ov || m_pristine) begin
          chk("cyc_quo", 32'(quo), 32'(m_quo));
          chk("cyc_rem", 32'(rem), 32'(m_rem));
          chk("cyc_div_zero", 32'(div_zero), 32'(m_dz));
          chk("cyc_ovf", 32'(ovf), 32'(m_ovf));
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_quo", 32'(quo), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_ready", 32'(in_ready), 32'd1);
    chk("post_reset_valid", 32'(out_valid), 32'd0);

    do_op(16'd1000, 8'd7,    1'b0, 16'd142,   8'd6,    1'b0, 1'b0, 19, 0, 1'b0);
    do_op(16'hFC18, 8'd7,    1'b1, 16'hFF72,  8'hFA,   1'b0, 1'b0, 19, 0, 1'b0);
    do_op(16'd1000, 8'hF9,   1'b1, 16'hFF72,  8'd6,    1'b0, 1'b0, 19, 0, 1'b0);
    do_op(16'h7FFF, 8'h80,   1'b1, 16'hFF01,  8'h7F,   1'b0, 1'b0, 19, 0, 1'b0);
    do_op(16'd1234, 8'd0,    1'b0, 16'hFFFF,  8'h00,   1'b1, 1'b0, 2,  0, 1'b0);
    do_op(16'd1234, 8'd0,    1'b1, 16'hFFFF,  8'h00,   1'b1, 1'b0, 2,  0, 1'b0);
    do_op(16'h8000, 8'hFF,   1'b1, 16'h8000,  8'h00,   1'b0, 1'b1, 2,  0, 1'b0);
    do_op(16'h8000, 8'hFF,   1'b0, 16'h0080,  8'h80,   1'b0, 1'b0, 19, 0, 1'b0);
    do_op(16'd500,  8'd9,    1'b0, 16'd55,    8'd5,    1'b0, 1'b0, 19, 5, 1'b1);
    do_op(16'd255,  8'd16,   1'b0, 16'd15,    8'd15,   1'b0, 1'b0, 19, 0, 1'b0);

    // Abort an operation mid-iteration with an asynchronous reset.
    N = 16'd1000; D = 8'd7; Signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_quo", 32'(quo), 32'd0);
    chk("abort_rem", 32'(rem), 32'd0);
    chk("abort_flags", 32'({div_zero, ovf}), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready_after", 32'(in_ready), 32'd1);
    chk("abort_valid_after", 32'(out_valid), 32'd0);

    do_op(16'd65535, 8'd255, 1'b0, 16'd257,  8'd0,    1'b0, 1'b0, 19, 0, 1'b0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
